mcpu_alu_sequencer: RTL and testbench

Multi-cycle execute controller that sits directly upstream of the MCPU 2-bit ALU and feeds it. It accepts one decoded instruction at a time over a valid/ready handshake and reads its operands from a small internal register file. It drives the ALU's cmd/in1/in2 from registers, samples the ALU result after a fixed settle time, and writes the result back to the register file. It also keeps the architectural carry flag, which changes only on ADD.

---
 rtl/mcpu_alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_mcpu_alu_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_alu_sequencer.sv
// mcpu_alu_sequencer: multi-cycle execute controller feeding the MCPU 2-bit ALU.
// Accepts one decoded instruction at a time, reads operands from a small
// register file, holds the ALU inputs steady for ALU_WAIT cycles, then writes
// the ALU result back and updates the carry flag on ADD.
module mcpu_alu_sequencer #(
  parameter int CMD_SIZE  = 2,
  parameter int WORD_SIZE = 8,
  parameter int REG_ADDR  = 2,
  parameter int ALU_WAIT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [CMD_SIZE-1:0]  instr_cmd,
  input  logic [REG_ADDR-1:0]  instr_dst,
  input  logic [REG_ADDR-1:0]  instr_src1,
  input  logic [REG_ADDR-1:0]  instr_src2,
  input  logic                 instr_imm_sel,
  input  logic [WORD_SIZE-1:0] instr_imm,
  output logic [CMD_SIZE-1:0]  alu_cmd,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_cf,
  output logic                 res_valid,
  output logic [WORD_SIZE-1:0] res_data,
  output logic [REG_ADDR-1:0]  res_dst,
  output logic                 cf,
  input  logic [REG_ADDR-1:0]  rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);

  localparam int NUM_REGS = 1 << REG_ADDR;
  // Counter only needs to hold ALU_WAIT-1; keep at least one bit.
  localparam int CNT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
  localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(ALU_WAIT - 1);
  localparam logic [CMD_SIZE-1:0] CMD_ADD  = CMD_SIZE'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_sample;
  logic [CNT_W-1:0]     r_cnt;
  logic [REG_ADDR-1:0]  r_dst;
  logic [CMD_SIZE-1:0]  r_alu_cmd;
  logic [WORD_SIZE-1:0] r_alu_in1;
  logic [WORD_SIZE-1:0] r_alu_in2;
  logic [WORD_SIZE-1:0] r_res_data;
  logic [REG_ADDR-1:0]  r_res_dst;
  logic                 r_cf;
  logic [WORD_SIZE-1:0] r_regs [NUM_REGS];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus handshake / writeback strobes.
  always_comb begin
    w_state_next = r_state;
    instr_ready  = 1'b0;
    res_valid    = 1'b0;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_sample     = 1'b1;
          w_state_next = ST_WB;
        end
      end
      ST_WB: begin
        res_valid    = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture at accept, settle countdown, result and carry capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_dst      <= '0;
      r_alu_cmd  <= '0;
      r_alu_in1  <= '0;
      r_alu_in2  <= '0;
      r_res_data <= '0;
      r_res_dst  <= '0;
      r_cf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_cmd <= instr_cmd;
        r_alu_in1 <= r_regs[instr_src1];
        r_alu_in2 <= instr_imm_sel ? instr_imm : r_regs[instr_src2];
        r_dst     <= instr_dst;
        r_cnt     <= CNT_INIT;
      end else if (r_state == ST_EXEC && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_sample) begin
        r_res_data <= alu_out;
        r_res_dst  <= r_dst;
        if (r_alu_cmd == CMD_ADD) begin
          r_cf <= alu_cf;
        end
      end
    end
  end

  // Register file: cleared on reset, single writeback port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_sample) begin
      r_regs[r_dst] <= alu_out;
    end
  end

  assign alu_cmd  = r_alu_cmd;
  assign alu_in1  = r_alu_in1;
  assign alu_in2  = r_alu_in2;
  assign res_data = r_res_data;
  assign res_dst  = r_res_dst;
  assign cf       = r_cf;
  assign rd_data  = r_regs[rd_addr];

endmodule

// File: tb/tb_mcpu_alu_sequencer.sv
// Testbench for mcpu_alu_sequencer: a default build (ALU_WAIT=1) driven by a
// vector table and random instructions, and an ALU_WAIT=3 build for latency
// and reset-during-EXEC. The ALU itself is modelled here.
module tb_mcpu_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_instr  = 0;

  // ---------------- instance A: ALU_WAIT = 1 ----------------
  logic       a_reset, a_instr_valid, a_instr_ready, a_instr_imm_sel;
  logic [1:0] a_instr_cmd, a_instr_dst, a_instr_src1, a_instr_src2;
  logic [7:0] a_instr_imm;
  logic [1:0] a_alu_cmd;
  logic [7:0] a_alu_in1, a_alu_in2, a_alu_out;
  logic       a_alu_cf, a_res_valid, a_cf;
  logic [7:0] a_res_data, a_rd_data;
  logic [1:0] a_res_dst, a_rd_addr;
  logic [8:0] a_sum;

  mcpu_alu_sequencer #(.CMD_SIZE(2), .WORD_SIZE(8), .REG_ADDR(2), .ALU_WAIT(1)) u_dut_a (
    .clk(clk), .reset(a_reset),
    .instr_valid(a_instr_valid), .instr_ready(a_instr_ready),
    .instr_cmd(a_instr_cmd), .instr_dst(a_instr_dst),
    .instr_src1(a_instr_src1), .instr_src2(a_instr_src2),
    .instr_imm_sel(a_instr_imm_sel), .instr_imm(a_instr_imm),
    .alu_cmd(a_alu_cmd), .alu_in1(a_alu_in1), .alu_in2(a_alu_in2),
    .alu_out(a_alu_out), .alu_cf(a_alu_cf),
    .res_valid(a_res_valid), .res_data(a_res_data), .res_dst(a_res_dst),
    .cf(a_cf), .rd_addr(a_rd_addr), .rd_data(a_rd_data)
  );

  // ALU model for instance A; carry is the add carry regardless of cmd.
  assign a_sum    = {1'b0, a_alu_in1} + {1'b0, a_alu_in2};
  assign a_alu_cf = a_sum[8];
  always_comb begin
    a_alu_out = a_sum[7:0];
    case (a_alu_cmd)
      2'd0: a_alu_out = a_alu_in1 & a_alu_in2;
      2'd1: a_alu_out = a_alu_in1 | a_alu_in2;
      2'd2: a_alu_out = a_alu_in1 ^ a_alu_in2;
      default: a_alu_out = a_sum[7:0];
    endcase
  end

  // ---------------- instance B: ALU_WAIT = 3 ----------------
  logic       b_reset, b_instr_valid, b_instr_ready, b_instr_imm_sel;
  logic [1:0] b_instr_cmd, b_instr_dst, b_instr_src1, b_instr_src2;
  logic [7:0] b_instr_imm;
  logic [1:0] b_alu_cmd;
  logic [7:0] b_alu_in1, b_alu_in2, b_alu_out;
  logic       b_alu_cf, b_res_valid, b_cf;
  logic [7:0] b_res_data, b_rd_data;
  logic [1:0] b_res_dst, b_rd_addr;
  logic [8:0] b_sum;

  mcpu_alu_sequencer #(.CMD_SIZE(2), .WORD_SIZE(8), .REG_ADDR(2), .ALU_WAIT(3)) u_dut_b (
    .clk(clk), .reset(b_reset),
    .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
    .instr_cmd(b_instr_cmd), .instr_dst(b_instr_dst),
    .instr_src1(b_instr_src1), .instr_src2(b_instr_src2),
    .instr_imm_sel(b_instr_imm_sel), .instr_imm(b_instr_imm),
    .alu_cmd(b_alu_cmd), .alu_in1(b_alu_in1), .alu_in2(b_alu_in2),
    .alu_out(b_alu_out), .alu_cf(b_alu_cf),
    .res_valid(b_res_valid), .res_data(b_res_data), .res_dst(b_res_dst),
    .cf(b_cf), .rd_addr(b_rd_addr), .rd_data(b_rd_data)
  );

  // ALU model for instance B.
  assign b_sum    = {1'b0, b_alu_in1} + {1'b0, b_alu_in2};
  assign b_alu_cf = b_sum[8];
  always_comb begin
    b_alu_out = b_sum[7:0];
    case (b_alu_cmd)
      2'd0: b_alu_out = b_alu_in1 & b_alu_in2;
      2'd1: b_alu_out = b_alu_in1 | b_alu_in2;
      2'd2: b_alu_out = b_alu_in1 ^ b_alu_in2;
      default: b_alu_out = b_sum[7:0];
    endcase
  end

  // ---------------- reference model state (instance A) ----------------
  logic [7:0] m_regs [4];
  logic       m_cf;

  typedef struct {
    logic [1:0] cmd, dst, s1, s2;
    logic       imm_sel;
    logic [7:0] imm;
    logic [7:0] exp_res;
    logic       exp_cf;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction semantics from plain arithmetic.
  function automatic void ref_exec(input logic [1:0] cmd, input logic [7:0] a, input logic [7:0] b,
                                   input logic cf_in, output logic [7:0] res, output logic cf_out);
    int sum;
    sum    = int'(a) + int'(b);
    cf_out = cf_in;
    case (cmd)
      2'd0: res = a & b;
      2'd1: res = a | b;
      2'd2: res = a ^ b;
      default: begin
        res    = 8'(sum % 256);
        cf_out = (sum > 255);
      end
    endcase
  endfunction

  task automatic scramble_a();
    a_instr_valid   = 1'($urandom);
    a_instr_cmd     = 2'($urandom);
    a_instr_dst     = 2'($urandom);
    a_instr_src1    = 2'($urandom);
    a_instr_src2    = 2'($urandom);
    a_instr_imm_sel = 1'($urandom);
    a_instr_imm     = 8'($urandom);
  endtask

  // Issue one instruction on A. Entered and left at a negedge in IDLE.
  task automatic issue_a(input logic [1:0] cmd, input logic [1:0] dst, input logic [1:0] s1,
                         input logic [1:0] s2, input logic imm_sel, input logic [7:0] imm,
                         input logic [7:0] exp_res, input logic exp_cf);
    logic [7:0] op1, op2;
    op1 = m_regs[s1];
    op2 = imm_sel ? imm : m_regs[s2];
    check("idle_ready", a_instr_ready, 1);
    a_instr_cmd = cmd; a_instr_dst = dst; a_instr_src1 = s1; a_instr_src2 = s2;
    a_instr_imm_sel = imm_sel; a_instr_imm = imm; a_instr_valid = 1'b1;
    @(negedge clk);  // EXEC
    check("exec_ready", a_instr_ready, 0);
    check("exec_res_valid", a_res_valid, 0);
    check("exec_alu_cmd", a_alu_cmd, cmd);
    check("exec_alu_in1", a_alu_in1, op1);
    check("exec_alu_in2", a_alu_in2, op2);
    check("exec_cf_hold", a_cf, m_cf);
    a_rd_addr = dst;
    scramble_a();
    @(negedge clk);  // WB
    check("wb_res_valid", a_res_valid, 1);
    check("wb_ready", a_instr_ready, 0);
    check("wb_res_data", a_res_data, exp_res);
    check("wb_res_dst", a_res_dst, dst);
    check("wb_cf", a_cf, exp_cf);
    check("wb_rd_data", a_rd_data, exp_res);
    scramble_a();
    @(negedge clk);  // IDLE again
    check("post_ready", a_instr_ready, 1);
    check("post_res_valid", a_res_valid, 0);
    check("hold_res_data", a_res_data, exp_res);
    check("hold_alu_in1", a_alu_in1, op1);
    a_instr_valid = 1'b0;
    m_regs[dst] = exp_res;
    m_cf        = exp_cf;
    n_instr++;
    $display("instr %0d: cmd=%0d dst=%0d src1=%0d src2=%0d imm_sel=%0b imm=0x%02h -> res=0x%02h cf=%0b",
             n_instr, cmd, dst, s1, s2, imm_sel, imm, a_res_data, a_cf);
  endtask

  // Watchdog: the run must always terminate.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- instance A stimulus ----------------
  initial begin : stim_a
    logic [1:0] cmd, dst, s1, s2;
    logic       sel, rcf;
    logic [7:0] imm, op2, res;

    // table: hand-derived results, applied back to back from reset state
    vecs[0] = '{2'd1, 2'd1, 2'd0, 2'd0, 1'b1, 8'h5A, 8'h5A, 1'b0}; // OR  r1 = r0 | 5A
    vecs[1] = '{2'd2, 2'd1, 2'd1, 2'd0, 1'b1, 8'hAA, 8'hF0, 1'b0}; // XOR r1 = 5A ^ AA
    vecs[2] = '{2'd3, 2'd2, 2'd1, 2'd0, 1'b1, 8'h20, 8'h10, 1'b1}; // ADD r2 = F0 + 20, carry
    vecs[3] = '{2'd2, 2'd3, 2'd2, 2'd0, 1'b1, 8'hFF, 8'hEF, 1'b1}; // XOR r3 = 10 ^ FF, cf holds
    vecs[4] = '{2'd3, 2'd0, 2'd3, 2'd1, 1'b0, 8'h00, 8'hDF, 1'b1}; // ADD r0 = EF + F0
    vecs[5] = '{2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F, 8'h0F, 1'b1}; // AND r1 = DF & 0F
    vecs[6] = '{2'd1, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00, 8'hEF, 1'b1}; // OR  r2 = 0F | EF
    vecs[7] = '{2'd3, 2'd3, 2'd2, 2'd0, 1'b1, 8'h01, 8'hF0, 1'b0}; // ADD r3 = EF + 01
    vecs[8] = '{2'd3, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'h1E, 1'b0}; // ADD r1 = r1 + r1 alias

    a_reset = 1'b1; a_instr_valid = 1'b0; a_instr_cmd = '0; a_instr_dst = '0;
    a_instr_src1 = '0; a_instr_src2 = '0; a_instr_imm_sel = 1'b0; a_instr_imm = '0; a_rd_addr = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_cf = 1'b0;
    repeat (2) @(negedge clk);
    a_reset = 1'b0;
    @(negedge clk);
    check("rst_ready", a_instr_ready, 1);
    check("rst_res_valid", a_res_valid, 0);
    check("rst_cf", a_cf, 0);
    check("rst_alu_cmd", a_alu_cmd, 0);
    check("rst_alu_in1", a_alu_in1, 0);
    check("rst_alu_in2", a_alu_in2, 0);
    check("rst_res_data", a_res_data, 0);
    check("rst_res_dst", a_res_dst, 0);
    for (int i = 0; i < 4; i++) begin
      a_rd_addr = 2'(i);
      #1;
      check("rst_rd_data", a_rd_data, 0);
    end
    @(negedge clk);

    // vector table, back to back (valid never low at an IDLE edge)
    for (int i = 0; i < 9; i++) begin
      issue_a(vecs[i].cmd, vecs[i].dst, vecs[i].s1, vecs[i].s2, vecs[i].imm_sel,
              vecs[i].imm, vecs[i].exp_res, vecs[i].exp_cf);
    end

    // random instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      cmd = 2'($urandom); dst = 2'($urandom); s1 = 2'($urandom); s2 = 2'($urandom);
      sel = 1'($urandom); imm = 8'($urandom);
      op2 = sel ? imm : m_regs[s2];
      ref_exec(cmd, m_regs[s1], op2, m_cf, res, rcf);
      issue_a(cmd, dst, s1, s2, sel, imm, res, rcf);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    for (int i = 0; i < 4; i++) begin
      a_rd_addr = 2'(i);
      #1;
      check("final_rd_data", a_rd_data, m_regs[i]);
    end
    check("final_cf", a_cf, m_cf);
  end

  // ---------------- instance B stimulus and summary ----------------
  initial begin : stim_b
    int pulses;
    int lat;
    bit seen;

    b_reset = 1'b1; b_instr_valid = 1'b0; b_instr_cmd = '0; b_instr_dst = '0;
    b_instr_src1 = '0; b_instr_src2 = '0; b_instr_imm_sel = 1'b0; b_instr_imm = '0; b_rd_addr = '0;
    repeat (2) @(negedge clk);
    b_reset = 1'b0;
    @(negedge clk);
    check("b_rst_ready", b_instr_ready, 1);

    // OR r2 = r0 | 77 with three settle cycles
    b_instr_cmd = 2'd1; b_instr_dst = 2'd2; b_instr_src1 = 2'd0; b_instr_src2 = 2'd0;
    b_instr_imm_sel = 1'b1; b_instr_imm = 8'h77; b_instr_valid = 1'b1; b_rd_addr = 2'd2;
    @(negedge clk);
    b_instr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("b_exec_ready", b_instr_ready, 0);
      check("b_exec_res_valid", b_res_valid, 0);
      b_instr_cmd = 2'($urandom); b_instr_dst = 2'($urandom); b_instr_imm = 8'($urandom);
      @(negedge clk);
    end
    check("b_wb_res_valid", b_res_valid, 1);
    check("b_wb_res_data", b_res_data, 8'h77);
    check("b_wb_res_dst", b_res_dst, 2'd2);
    check("b_wb_rd_data", b_rd_data, 8'h77);
    @(negedge clk);
    check("b_idle_ready", b_instr_ready, 1);
    check("b_idle_res_valid", b_res_valid, 0);
    $display("b instr 1: OR dst=2 imm=0x77 -> res=0x%02h", b_res_data);

    // ADD r3 = 77 + 90, aborted by reset during EXEC
    b_instr_cmd = 2'd3; b_instr_dst = 2'd3; b_instr_src1 = 2'd2; b_instr_src2 = 2'd0;
    b_instr_imm_sel = 1'b1; b_instr_imm = 8'h90; b_instr_valid = 1'b1; b_rd_addr = 2'd3;
    @(negedge clk);
    b_instr_valid = 1'b0;
    check("b_abort_exec_ready", b_instr_ready, 0);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    check("b_abort_ready", b_instr_ready, 1);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (b_res_valid) pulses++;
    end
    check("b_abort_no_pulse", pulses, 0);
    check("b_abort_cf", b_cf, 0);
    check("b_abort_rd3", b_rd_data, 8'h00);
    b_rd_addr = 2'd2;
    #1;
    check("b_abort_rd2", b_rd_data, 8'h00);
    $display("b instr 2: ADD dst=3 aborted by reset, pulses=%0d", pulses);
    @(negedge clk);

    // next instruction accepted normally: OR r1 = r0 | 3C
    b_instr_cmd = 2'd1; b_instr_dst = 2'd1; b_instr_src1 = 2'd0; b_instr_src2 = 2'd0;
    b_instr_imm_sel = 1'b1; b_instr_imm = 8'h3C; b_instr_valid = 1'b1; b_rd_addr = 2'd1;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      b_instr_valid = 1'b0;
      if (b_res_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("b_next_seen", seen, 1);
    check("b_next_latency", lat, 4);
    check("b_next_res_data", b_res_data, 8'h3C);
    check("b_next_rd_data", b_rd_data, 8'h3C);
    $display("b instr 3: OR dst=1 imm=0x3C -> res=0x%02h latency=%0d", b_res_data, lat);

    // wait for instance A to finish its run (bounded)
    wait (n_instr >= 49 || $time > 150000);
    repeat (4) @(negedge clk);
    check("a_instr_count", n_instr, 49);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
